// File: rtl/k12_pkg.sv
// k12 fetch-unit shared definitions: fetch state encoding, widths and PC steps.
package k12_pkg;

  localparam int unsigned K12_INST_W = 16;
  localparam int unsigned K12_ADDR_W = 16;

  localparam logic [1:0] K12_SKIP_OPC = 2'b11;

  localparam logic [K12_ADDR_W-1:0] K12_PC_INC      = 16'd2;
  localparam logic [K12_ADDR_W-1:0] K12_PC_SKIP_INC = 16'd4;

  typedef enum logic [1:0] {
    START,
    FETCH_HI,
    FETCH_LO,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/k12_fetch_buf.sv
// k12 one-entry prefetch buffer: fetches one 16-bit instruction (big-endian,
// two byte transactions) and holds it until taken or flushed. A flush that
// arrives mid-transaction lets the transaction finish and drops its data.
module k12_fetch_buf
  import k12_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [K12_ADDR_W-1:0] start_addr,
  input  logic                  flush,
  input  logic                  take,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  full,
  output logic [K12_ADDR_W-1:0] addr,
  output logic [K12_INST_W-1:0] data
);

  logic                  busy_q, busy_d;
  logic                  lo_q, lo_d;
  logic                  full_q, full_d;
  logic                  discard_q, discard_d;
  logic [K12_ADDR_W-1:0] addr_q, addr_d;
  logic [K12_INST_W-1:0] data_q, data_d;

  // Byte assembly, fill/take bookkeeping and discard of abandoned fetches.
  always_comb begin
    busy_d    = busy_q;
    lo_d      = lo_q;
    full_d    = full_q;
    discard_d = discard_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (start && !busy_q) begin
      busy_d    = 1'b1;
      lo_d      = 1'b0;
      addr_d    = start_addr;
      discard_d = 1'b0;
    end
    if (busy_q && mem_ack) begin
      if (!lo_q) begin
        data_d[15:8] = mem_rdata;
        lo_d         = 1'b1;
        addr_d       = addr_q + 16'd1;
      end else begin
        data_d[7:0] = mem_rdata;
        busy_d      = 1'b0;
        lo_d        = 1'b0;
        full_d      = !discard_q;
        discard_d   = 1'b0;
      end
    end
    if (take) begin
      full_d = 1'b0;
    end
    // A flush empties the entry and poisons any transaction still in flight.
    if (flush) begin
      full_d    = 1'b0;
      discard_d = busy_d;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      lo_q      <= 1'b0;
      full_q    <= 1'b0;
      discard_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      busy_q    <= busy_d;
      lo_q      <= lo_d;
      full_q    <= full_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign busy = busy_q;
  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/k12_fetch.sv
// k12 instruction fetch unit: assembles big-endian 16-bit instructions from a
// byte memory port, presents them with valid/ready, resolves jumps and
// conditional skips. Define K12_FETCH_PREFETCH_EN for a one-entry prefetch.
module k12_fetch
  import k12_pkg::*;
#(
  parameter logic [K12_ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [1:0]            SKIP_OPC = K12_SKIP_OPC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [K12_ADDR_W-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic [K12_INST_W-1:0] inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  cond,
  input  logic                  jump,
  input  logic [K12_ADDR_W-1:0] jump_target,
  output logic [K12_ADDR_W-1:0] pc
);

  localparam logic [K12_ADDR_W-1:0] RESET_PC_EVEN = {RESET_PC[K12_ADDR_W-1:1], 1'b0};

  fetch_state_e          state_q, state_d;
  logic [K12_ADDR_W-1:0] pc_q, pc_d;
  logic [K12_INST_W-1:0] inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  mem_req_q, mem_req_d;
  logic [K12_ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic                  accept, skip_taken, redirect, core_ack, promote;
  logic [K12_ADDR_W-1:0] next_pc;
  logic [K12_INST_W-1:0] promote_inst;

  // Accept decode and next-PC selection (jump beats a taken skip).
  always_comb begin
    accept     = (state_q == HOLD) && inst_valid_q && inst_ready;
    skip_taken = (inst_q[15:14] == SKIP_OPC) && cond;
    redirect   = jump || skip_taken;
    if (jump) begin
      next_pc = jump_target & 16'hFFFE;
    end else if (skip_taken) begin
      next_pc = pc_q + K12_PC_SKIP_INC;
    end else begin
      next_pc = pc_q + K12_PC_INC;
    end
  end

`ifdef K12_FETCH_PREFETCH_EN
  logic                  buf_start, buf_take, buf_flush, buf_busy, buf_full;
  logic [K12_ADDR_W-1:0] buf_addr;
  logic [K12_INST_W-1:0] buf_data;

  // The buffer owns the memory port while busy; the core FSM waits it out
  // so a redirected fetch never cuts an outstanding request short.
  always_comb begin
    buf_start    = (state_q == HOLD) && !accept && !buf_busy && !buf_full;
    buf_take     = accept && !redirect && buf_full;
    buf_flush    = accept && !buf_take;
    promote      = buf_take;
    promote_inst = buf_data;
    core_ack     = mem_ack && !buf_busy;
    mem_req      = mem_req_q || buf_busy;
    mem_addr     = buf_busy ? buf_addr : mem_addr_q;
  end

  k12_fetch_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (buf_start),
    .start_addr (pc_q + K12_PC_INC),
    .flush      (buf_flush),
    .take       (buf_take),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (buf_busy),
    .full       (buf_full),
    .addr       (buf_addr),
    .data       (buf_data)
  );
`else
  // Without prefetch the core FSM is the only memory requester.
  always_comb begin
    promote      = 1'b0;
    promote_inst = '0;
    core_ack     = mem_ack;
    mem_req      = mem_req_q;
    mem_addr     = mem_addr_q;
  end
`endif

  // Fetch FSM next state; memory outputs are set one state ahead so they
  // come straight from flops.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      START: begin
        state_d    = FETCH_HI;
        mem_req_d  = 1'b1;
        mem_addr_d = pc_q;
      end
      FETCH_HI: begin
        if (core_ack) begin
          inst_d[15:8] = mem_rdata;
          state_d      = FETCH_LO;
          mem_addr_d   = pc_q + 16'd1;
        end
      end
      FETCH_LO: begin
        if (core_ack) begin
          inst_d[7:0]  = mem_rdata;
          inst_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          pc_d = next_pc;
          if (promote) begin
            inst_d = promote_inst;
          end else begin
            state_d      = FETCH_HI;
            inst_valid_d = 1'b0;
            mem_req_d    = 1'b1;
            mem_addr_d   = next_pc;
          end
        end
      end
      default: state_d = START;
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= START;
      pc_q         <= RESET_PC_EVEN;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= RESET_PC_EVEN;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_k12_fetch.sv
// Bench for k12_fetch: behavioural byte memory with programmable ack delay,
// port-protocol monitor and an architectural next-PC reference model.
module tb_k12_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        cond;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] pc;

  always #5 clk = ~clk;

  k12_fetch #(.RESET_PC(16'h0000), .SKIP_OPC(2'b11)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .inst(inst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .cond(cond),
    .jump(jump), .jump_target(jump_target), .pc(pc)
  );

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  // Sparse memory image; unwritten bytes get random contents on first touch.
  logic [7:0] mem [logic [15:0]];
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic logic [15:0] exp_inst(input logic [15:0] p);
    return {mem_byte(p), mem_byte(16'(p + 16'd1))};
  endfunction

  // Architectural next PC: jump target (even), else skip-by-two on a taken skip.
  function automatic logic [15:0] model_next(input logic [15:0] p, input logic [15:0] i,
                                             input bit c, input bit j, input logic [15:0] t);
    int unsigned step;
    if (j) return 16'(t - (t % 2));
    step = ((i >> 14) == 3 && c) ? 4 : 2;
    return 16'((int'(p) + step) % 65536);
  endfunction

  // Memory responder and protocol monitor, both on the falling edge.
  int unsigned ack_delay = 0;
  int unsigned wait_cnt = 0;
  bit          stray_ack = 1'b0;
  logic [15:0] ack_log [$];
  bit          prev_req = 1'b0, prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;
  int unsigned proto_viol = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && prev_req && !prev_ack && !(mem_req === 1'b1 && mem_addr === prev_addr))
      proto_viol++;
`ifndef K12_FETCH_PREFETCH_EN
    if (rst_n === 1'b1 && inst_valid === 1'b1 && mem_req !== 1'b0) proto_viol++;
`endif
    prev_req  = (mem_req === 1'b1);
    prev_addr = mem_addr;
    if (mem_req === 1'b1) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_byte(mem_addr);
        ack_log.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      wait_cnt  = 0;
      mem_ack   = stray_ack;
      mem_rdata = 8'hA5;
    end
    prev_ack = mem_ack;
  end

  logic [15:0] ref_pc;
  int unsigned log_mark;

  // Issue one accept at the current negedge; updates the reference PC.
  task automatic do_accept(input bit c, input bit j, input logic [15:0] t);
    logic [15:0] cur;
    cur         = exp_inst(ref_pc);
    log_mark    = ack_log.size();
    inst_ready  = 1'b1;
    cond        = c;
    jump        = j;
    jump_target = t;
    @(posedge clk);
    #1;
    inst_ready  = 1'b0;
    cond        = 1'b0;
    jump        = 1'b0;
    ref_pc      = model_next(ref_pc, cur, c, j, t);
  endtask

  // Count falling edges until inst_valid (first one after an accept is 1).
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (inst_valid !== 1'b1 && n < budget);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inst_ready = 1'b0; cond = 1'b0; jump = 1'b0; jump_target = '0;
    mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34;
    repeat (2) @(negedge clk);
    n_cmp++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    n_cmp++; if (inst !== 16'h0000) begin n_fail++; $display("FAIL reset_inst got=%h exp=0000", inst); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h exp=0000", mem_addr); end
    rst_n = 1'b1;
    ref_pc = 16'h0000;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL first_hi req=%b addr=%h exp req=1 addr=0000", mem_req, mem_addr); end
    @(negedge clk);
    n_cmp++; if (mem_addr !== 16'h0001 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL first_lo addr=%h valid=%b exp addr=0001 valid=0", mem_addr, inst_valid); end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst !== 16'h1234 || pc !== 16'h0000) begin n_fail++; $display("FAIL first_inst valid=%b inst=%h pc=%h exp 1 1234 0000", inst_valid, inst, pc); end
  endtask

  task automatic test_skip;
    int n;
    mem[16'h0010] = 8'hC1; mem[16'h0011] = 8'h05;
    do_accept(1'b0, 1'b1, 16'h0010);
    wait_valid(20, n);
    n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL accept_latency got=%0d exp=3", n); end
    n_cmp++; if (inst !== 16'hC105 || pc !== 16'h0010) begin n_fail++; $display("FAIL skip_setup inst=%h pc=%h exp C105 0010", inst, pc); end
    do_accept(1'b1, 1'b0, 16'h0000);
    wait_valid(20, n);
    n_cmp++; if (pc !== 16'h0014 || pc !== ref_pc) begin n_fail++; $display("FAIL skip_taken pc=%h exp=0014", pc); end
    n_cmp++; if (ack_log.size() < log_mark + 2 || ack_log[log_mark] !== 16'h0014 || ack_log[log_mark+1] !== 16'h0015)
      begin n_fail++; $display("FAIL skip_taken_addr first fetch not at 0014/0015"); end
    do_accept(1'b0, 1'b1, 16'h0010);
    wait_valid(20, n);
    do_accept(1'b0, 1'b0, 16'hFFFF);
    wait_valid(20, n);
    n_cmp++; if (pc !== 16'h0012 || inst !== exp_inst(16'h0012)) begin n_fail++; $display("FAIL skip_not_taken pc=%h inst=%h exp pc=0012 inst=%h", pc, inst, exp_inst(16'h0012)); end
  endtask

  task automatic test_jump;
    int n;
    mem[16'h0100] = 8'hC0; mem[16'h0101] = 8'h00;
    do_accept(1'b0, 1'b1, 16'h0100);
    wait_valid(20, n);
    do_accept(1'b1, 1'b1, 16'h0203);
    wait_valid(20, n);
    n_cmp++; if (pc !== 16'h0202 || inst !== exp_inst(16'h0202)) begin n_fail++; $display("FAIL jump_priority pc=%h inst=%h exp pc=0202 inst=%h", pc, inst, exp_inst(16'h0202)); end
  endtask

  task automatic test_delayed_ack;
    int n;
    logic [15:0] hold_inst, hold_pc;
    ack_delay = 3;
    do_accept(1'b0, 1'b0, 16'h0000);
    wait_valid(40, n);
    n_cmp++; if (n !== 9) begin n_fail++; $display("FAIL delayed_latency got=%0d exp=9", n); end
    n_cmp++; if (inst !== exp_inst(ref_pc) || pc !== ref_pc) begin n_fail++; $display("FAIL delayed_inst inst=%h pc=%h exp %h %h", inst, pc, exp_inst(ref_pc), ref_pc); end
    ack_delay = 0;
    hold_inst = exp_inst(ref_pc); hold_pc = ref_pc;
    stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst !== hold_inst || pc !== hold_pc || inst_valid !== 1'b1) begin n_fail++; $display("FAIL stray_ack inst=%h pc=%h valid=%b exp %h %h 1", inst, pc, inst_valid, hold_inst, hold_pc); end
  endtask

  task automatic test_wrap;
    int n;
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h34;
    do_accept(1'b0, 1'b1, 16'hFFFE);
    wait_valid(20, n);
    n_cmp++; if (ack_log.size() < log_mark + 2 || ack_log[log_mark] !== 16'hFFFE || ack_log[log_mark+1] !== 16'hFFFF)
      begin n_fail++; $display("FAIL wrap_bytes fetch addresses not FFFE/FFFF"); end
    n_cmp++; if (inst !== 16'h1234 || pc !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_inst inst=%h pc=%h exp 1234 FFFE", inst, pc); end
    do_accept(1'b1, 1'b0, 16'h0000);
    wait_valid(20, n);
    n_cmp++; if (pc !== 16'h0000 || inst !== exp_inst(16'h0000)) begin n_fail++; $display("FAIL wrap_pc pc=%h exp=0000", pc); end
  endtask

  task automatic test_random;
    int n;
    bit c, j;
    logic [15:0] t;
    for (int k = 0; k < 40; k++) begin
      ack_delay = $urandom_range(0, 2);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b1 || inst !== exp_inst(ref_pc) || pc !== ref_pc)
        begin n_fail++; $display("FAIL random_hold[%0d] valid=%b inst=%h pc=%h exp 1 %h %h", k, inst_valid, inst, pc, exp_inst(ref_pc), ref_pc); end
      c = 1'($urandom);
      j = ($urandom_range(0, 3) == 0);
      t = 16'($urandom);
      do_accept(c, j, t);
      wait_valid(60, n);
      n_cmp++; if (inst_valid !== 1'b1 || inst !== exp_inst(ref_pc) || pc !== ref_pc)
        begin n_fail++; $display("FAIL random_next[%0d] valid=%b inst=%h pc=%h exp 1 %h %h", k, inst_valid, inst, pc, exp_inst(ref_pc), ref_pc); end
    end
    ack_delay = 0;
  endtask

`ifdef K12_FETCH_PREFETCH_EN
  task automatic test_prefetch;
    int n;
    logic [15:0] spec_pc;
    ack_delay = 0;
    repeat (6) @(negedge clk);
    do_accept(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst !== exp_inst(ref_pc) || pc !== ref_pc)
      begin n_fail++; $display("FAIL prefetch_zero_bubble valid=%b inst=%h pc=%h exp 1 %h %h", inst_valid, inst, pc, exp_inst(ref_pc), ref_pc); end
    ack_delay = 4;
    spec_pc = 16'(ref_pc + 16'd2);
    @(negedge clk);
    do_accept(1'b0, 1'b1, 16'h0400);
    wait_valid(80, n);
    n_cmp++; if (inst_valid !== 1'b1 || pc !== 16'h0400 || inst !== exp_inst(16'h0400))
      begin n_fail++; $display("FAIL prefetch_jump valid=%b pc=%h inst=%h exp 1 0400 %h", inst_valid, pc, inst, exp_inst(16'h0400)); end
    n_cmp++; if (ack_log.size() != log_mark + 4 || ack_log[log_mark] !== spec_pc || ack_log[log_mark+2] !== 16'h0400 || ack_log[log_mark+3] !== 16'h0401)
      begin n_fail++; $display("FAIL prefetch_discard log entries=%0d exp=4", ack_log.size() - log_mark); end
    ack_delay = 0;
  endtask
`endif

  task automatic test_reset_mid;
    int n;
    ack_delay = 5;
    do_accept(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 16'h0000)
      begin n_fail++; $display("FAIL reset_mid req=%b valid=%b pc=%h exp 0 0 0000", mem_req, inst_valid, pc); end
    ack_delay = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ref_pc = 16'h0000;
    wait_valid(20, n);
    n_cmp++; if (n !== 3 || inst !== 16'h1234 || pc !== 16'h0000)
      begin n_fail++; $display("FAIL reset_mid_refetch n=%0d inst=%h pc=%h exp 3 1234 0000", n, inst, pc); end
  endtask

  task automatic test_protocol;
    n_cmp++;
    if (proto_viol !== 0) begin n_fail++; $display("FAIL mem_protocol violations=%0d exp=0", proto_viol); end
  endtask

  initial begin
    test_reset();
    test_skip();
    test_jump();
    test_delayed_ack();
    test_wrap();
    test_random();
`ifdef K12_FETCH_PREFETCH_EN
    test_prefetch();
`endif
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/k12_fetch.md
Name: k12_fetch

Overview:
Instruction fetch unit for the k12 core. It is the producer side of the ALU's instruction interface: it assembles 16-bit instructions from a byte-wide memory port, presents them to the execute stage with a valid/ready handshake, and consumes the ALU's cond result to resolve conditional skips. It maintains the program counter and applies jump redirects from the execute stage.

Parameters:
RESET_PC, 16'h0000, program counter value after reset; bit 0 is ignored (forced 0).
SKIP_OPC, 2'b11, value of inst[15:14] that marks a conditional-skip instruction.

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_addr  output  16  byte address of current memory request
mem_req  output  1  memory request; held high with stable mem_addr until mem_ack
mem_ack  input  1  memory acknowledge; mem_rdata valid in the same cycle
mem_rdata  input  8  memory read data
inst  output  16  instruction to execute stage (drives ALU inst)
inst_valid  output  1  inst holds a fetched instruction
inst_ready  input  1  execute stage accepts inst this cycle
cond  input  1  ALU condition for the presented inst; sampled only on accept
jump  input  1  redirect on accept; higher priority than skip
jump_target  input  16  redirect address; bit 0 forced 0
pc  output  16  address of the instruction currently in inst

Behaviour:
- Reset (async): state START, pc=RESET_PC, inst=16'h0000, inst_valid=0, mem_req=0, mem_addr=RESET_PC.
- States: START -> FETCH_HI (unconditional, 1 cycle). FETCH_HI: mem_req=1, mem_addr=fetch_pc; on mem_ack latch rdata into inst[15:8] and go to FETCH_LO. FETCH_LO: mem_req=1, mem_addr=fetch_pc+1; on mem_ack latch inst[7:0], set inst_valid=1 and go to HOLD. HOLD: inst_valid=1, mem_req=0.
- Big-endian: high byte at the even address. fetch_pc+1 and all PC increments wrap modulo 2^16 (0xFFFE+2 = 0x0000).
- Accept = inst_valid & inst_ready in HOLD. On accept the next pc is: jump ? {jump_target[15:1],0} : (inst[15:14]==SKIP_OPC & cond) ? pc+4 : pc+2. inst_valid drops the next cycle, state goes to FETCH_HI, and fetch_pc becomes the next pc.
- Minimum latency with single-cycle ack: accept at edge t; FETCH_HI in cycle t+1; FETCH_LO in t+2; inst_valid in t+3.
- mem_ack outside FETCH_HI/FETCH_LO is ignored. inst and pc are stable while inst_valid=1 and not yet accepted.
- jump and cond are don't-care without accept.
- Reset mid-transaction drops mem_req immediately. Memory must tolerate a request abandoned by reset.

Optional Feature:
Macro K12_FETCH_PREFETCH_EN.
- Defined: a one-entry prefetch buffer. While in HOLD, the unit fetches the instruction at pc+2 into the buffer.
- On accept with no jump and no taken skip, if the buffer is full, the buffered instruction is presented in the next cycle (inst_valid stays 1, zero bubble) and prefetch of the following instruction starts.
- On jump or taken skip, buffer contents are discarded. An outstanding memory transaction must still complete (mem_req is never dropped before mem_ack); its data is discarded, then fetch starts at the redirect address.
- Undefined: no buffer; behaviour exactly as above. mem_req is 0 whenever inst_valid=1.

Decomposition:
- Package k12_pkg: fetch state enum (START, FETCH_HI, FETCH_LO, HOLD), K12_INST_W=16, K12_ADDR_W=16, K12_SKIP_OPC default, PC increment constants (2, 4).
- One sub-module: k12_fetch_buf, the prefetch buffer with its own hi/lo byte assembly and valid/discard flags. Instantiated only under K12_FETCH_PREFETCH_EN.

Test Plan:
1. Reset release, memory {0x00:0x12, 0x01:0x34}, ack same cycle -> mem_addr 0x0000 then 0x0001; inst=0x1234, inst_valid=1, pc=0x0000 in cycle 3.
2. Accept 0xC105 (skip class) with cond=1 at pc=0x0010 -> next fetch at 0x0014, pc=0x0014. Same instruction with cond=0 -> next fetch at 0x0012.
3. Accept with jump=1, jump_target=0x0203 and skip/cond=1 -> next fetch at 0x0202 (jump wins, bit 0 cleared).
4. Ack delayed 3 cycles on each byte -> mem_req and mem_addr held stable throughout; inst_valid only after the second ack. Stray mem_ack in HOLD -> no state change.
5. pc=0xFFFE, accept, no jump -> next fetch at 0x0000. Also fetch at 0xFFFE issues byte addresses 0xFFFE and 0xFFFF.
6. With K12_FETCH_PREFETCH_EN: back-to-back inst_ready=1 on sequential code -> inst_valid continuously 1 after the first fetch. Jump while the prefetch is outstanding -> outstanding ack is consumed and discarded, and the next inst comes from the jump target.
